// File: rtl/reg_arb_pkg.sv
// Shared definitions for the two-port register bank arbiter:
// FSM state encoding, requester ids, and the default geometry.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_ADDR_W = 2;

endpackage

// File: rtl/sync_reg_word.sv
// One register word of the bank: synchronous active-high clear
// (highest priority) and a load enable.
// Ports:
//   clk    - clock
//   clear  - synchronous clear, active high
//   en_i   - load enable
//   d_i    - load data
//   q_o    - stored word
module sync_reg_word
  import reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;

  // Clear wins over a load on the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      word_q <= '0;
    end else if (en_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter and sequencer sharing a small register bank between
// two single-word read/write requesters (A and B).
// Ports:
//   clk, clear                        - clock, synchronous active-high reset
//   req_x, we_x, addr_x, wdata_x      - command from requester x (a or b)
//   ack_x                             - one-cycle completion pulse to x
//   rdata                             - last read data, valid with ack
//   busy                              - transaction in progress (BUSY/RESP)
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              ack_b,
  output logic [WIDTH-1:0]  rdata,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              cmd_id_q,     cmd_id_d;
  logic              cmd_we_q,     cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q,   cmd_addr_d;
  logic [WIDTH-1:0]  cmd_wdata_q,  cmd_wdata_d;
  logic [WIDTH-1:0]  rdata_q,      rdata_d;
  logic              ack_a_q,      ack_a_d;
  logic              ack_b_q,      ack_b_d;
  logic              busy_q,       busy_d;

  logic              grant;
  logic [DEPTH-1:0]  word_en;
  logic [WIDTH-1:0]  bank_q [DEPTH];
  logic [WIDTH-1:0]  rd_word;

  // Bank storage: one word per address, loaded by the decoded enable.
  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    sync_reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .clear (clear),
      .en_i  (word_en[i]),
      .d_i   (cmd_wdata_q),
      .q_o   (bank_q[i])
    );
  end

  // Address decode: at most one enable, only while writing in BUSY.
  always_comb begin
    word_en = '0;
    if (state_q == BUSY && cmd_we_q) begin
      word_en[cmd_addr_q] = 1'b1;
    end
  end

  // Read mux; the bank reflects every write of earlier transactions.
  assign rd_word = bank_q[cmd_addr_q];

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_id_d     = cmd_id_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rdata_d      = rdata_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    busy_d       = 1'b0;
    grant        = REQ_A;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // On a tie the requester that was not served last wins.
          if (req_a && req_b) begin
            grant = ~last_grant_q;
          end else if (req_a) begin
            grant = REQ_A;
          end else begin
            grant = REQ_B;
          end
          cmd_id_d    = grant;
          cmd_we_d    = (grant == REQ_A) ? we_a    : we_b;
          cmd_addr_d  = (grant == REQ_A) ? addr_a  : addr_b;
          cmd_wdata_d = (grant == REQ_A) ? wdata_a : wdata_b;
          state_d     = BUSY;
          busy_d      = 1'b1;
        end
      end

      BUSY: begin
        if (!cmd_we_q) begin
          rdata_d = rd_word;
        end
        // Ack is registered so it appears exactly during RESP.
        ack_a_d = (cmd_id_q == REQ_A);
        ack_b_d = (cmd_id_q == REQ_B);
        state_d = RESP;
        busy_d  = 1'b1;
      end

      RESP: begin
        last_grant_d = cmd_id_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; clear also discards a write in flight via the bank clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_B;
      cmd_id_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rdata_q      <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_id_q     <= cmd_id_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rdata_q      <= rdata_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      busy_q       <= busy_d;
    end
  end

  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed vector table,
// hand-written multi-cycle sequences, and randomized transactions checked
// against a transaction-level model (memory array + last-served id).
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       clear;
  logic       req_a, we_a, req_b, we_b;
  logic [1:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       ack_a, ack_b, busy;
  logic [3:0] rdata;

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .WIDTH  (4),
    .ADDR_W (2)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .req_a   (req_a),
    .we_a    (we_a),
    .addr_a  (addr_a),
    .wdata_a (wdata_a),
    .ack_a   (ack_a),
    .req_b   (req_b),
    .we_b    (we_b),
    .addr_b  (addr_b),
    .wdata_b (wdata_b),
    .ack_b   (ack_b),
    .rdata   (rdata),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference model.
  logic [3:0] m_mem [4];
  logic       m_last;    // 0 = A served last, 1 = B served last
  logic [3:0] m_rdata;

  typedef struct {
    logic       ea;
    logic       wa;
    logic [1:0] aa;
    logic [3:0] da;
    logic       eb;
    logic       wb;
    logic [1:0] ab;
    logic [3:0] db;
    logic       drop;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_mem[i] = 4'd0;
    m_last  = 1'b1;
    m_rdata = 4'd0;
  endtask

  task automatic drop_all();
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  // One transaction from an idle DUT; both requests are held until the ack
  // unless drop is set, in which case they fall right after the sample edge.
  task automatic run_txn(input logic ea, input logic wa, input logic [1:0] aa,
                         input logic [3:0] da, input logic eb, input logic wb,
                         input logic [1:0] ab, input logic [3:0] db,
                         input logic drop, output logic [3:0] rd);
    logic       win;
    logic       xwe;
    logic [1:0] xaddr;
    logic [3:0] xwd;
    int         cyc;
    bit         got;
    win   = (ea && eb) ? ~m_last : (ea ? 1'b0 : 1'b1);
    xwe   = win ? wb : wa;
    xaddr = win ? ab : aa;
    xwd   = win ? db : da;

    @(posedge clk); #1;
    req_a = ea; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = eb; we_b = wb; addr_b = ab; wdata_b = db;
    @(posedge clk);
    if (drop) begin
      #1;
      drop_all();
    end
    cyc = 0;
    got = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (ack_a || ack_b) got = 1;
    end
    check("ack_latency", cyc, 2);
    check("ack_a", int'(ack_a), int'(win == 1'b0));
    check("ack_b", int'(ack_b), int'(win == 1'b1));
    check("busy_in_resp", int'(busy), 1);
    if (xwe) m_mem[xaddr] = xwd;
    else     m_rdata = m_mem[xaddr];
    m_last = win;
    check("rdata", int'(rdata), int'(m_rdata));
    rd = rdata;
    @(posedge clk); #1;
    drop_all();
    @(negedge clk);
    check("idle_after_ack", int'({busy, ack_a, ack_b}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rd;
    int         ack_cnt;
    int         last_ack_k;
    logic       exp_who;

    // Directed vector table (expected rdata derived by hand).
    //            ea    wa    aa    da     eb    wb    ab    db     drop  exp
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 4'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 4'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'hA};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 2'd1, 4'h5, 1'b0, 4'hA};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h5};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'hA};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 4'h0};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 4'h3, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 4'h3};
    vecs[13] = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 4'hA};
    vecs[14] = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 4'h5};
    vecs[15] = '{1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h5};

    clear = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = 2'd0; wdata_a = 4'd0;
    req_b = 1'b0; we_b = 1'b0; addr_b = 2'd0; wdata_b = 4'd0;
    model_clear();

    // Reset: two cycles of clear, all outputs low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({ack_a, ack_b, busy, rdata}), 0);
    @(posedge clk); #1;
    clear = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i].ea, vecs[i].wa, vecs[i].aa, vecs[i].da,
              vecs[i].eb, vecs[i].wb, vecs[i].ab, vecs[i].db,
              vecs[i].drop, rd);
      check($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].exp_rd));
    end

    // Round robin with both requesters held continuously after reset.
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    req_a = 1'b1; we_a = 1'b0; addr_a = 2'd0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 2'd1;
    @(posedge clk);
    ack_cnt    = 0;
    last_ack_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("rr_no_overlap", int'(ack_a && ack_b), 0);
      if (ack_a || ack_b) begin
        exp_who = ~m_last;
        m_last  = exp_who;
        check("rr_winner_is_b", int'(ack_b), int'(exp_who));
        check("rr_spacing", k - last_ack_k, (ack_cnt == 0) ? 2 : 3);
        ack_cnt++;
        last_ack_k = k;
      end
    end
    check("rr_ack_count", ack_cnt, 5);
    @(posedge clk); #1;
    drop_all();
    repeat (2) @(posedge clk);

    // Clear during BUSY of a write: no ack, write discarded.
    #1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd3; wdata_a = 4'hF;
    @(posedge clk); #1;
    drop_all();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("clear_mid_write_quiet", int'({ack_a, ack_b, busy}), 0);
    end
    // Next tie goes to A, and addr 3 still reads zero.
    run_txn(1'b1, 1'b0, 2'd3, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0, rd);
    check("clear_addr3_zero", int'(rd), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      int pat;
      pat = int'($urandom_range(0, 2));
      run_txn(pat != 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)),
              pat != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
